// File: rtl/nfsr_pkg.sv
// Shared definitions for the 24-bit NFSR transmitter and its receive-side synchroniser.
`timescale 1ns/1ps
package nfsr_pkg;

  localparam int WIDTH = 24;

  typedef enum logic {
    ACQ   = 1'b0,
    TRACK = 1'b1
  } sync_state_t;

  function automatic logic fb(input logic [WIDTH-1:0] r);
    return r[23] ^ r[22] ^ r[21] ^ r[16] ^ (r[12] & r[7]) ^ (r[3] & r[1]);
  endfunction

endpackage

// File: rtl/nfsr_core.sv
// 24-bit shift register with serial load and the NFSR feedback prediction.
`timescale 1ns/1ps
module nfsr_core
  import nfsr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic             din,
  output logic [WIDTH-1:0] q,
  output logic             pred
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], din};
    end
  end

  assign pred = fb(q);

endmodule

// File: rtl/nfsr_rx_sync.sv
// Receive-side NFSR synchroniser: acquires 24 raw bits, then tracks by predicting each bit.
`timescale 1ns/1ps
module nfsr_rx_sync
  import nfsr_pkg::*;
#(
  parameter int MAX_MISS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             Ser_in,
  output logic [WIDTH-1:0] Par_out,
  output logic             Locked,
  output logic             Mismatch,
  output logic [7:0]       Err_cnt
);

  localparam logic [2:0] MISS_LIMIT = 3'(MAX_MISS);

  sync_state_t state;
  sync_state_t state_next;
  logic [4:0]  acq_cnt;
  logic [2:0]  miss_cnt;
  logic        pred;
  logic        din;
  logic        locked_q;

  // While tracking, the register always advances on the prediction so a bad bit cannot corrupt it.
  assign din      = (state == TRACK) ? pred : Ser_in;
  assign Mismatch = !rst && shift_en && (state == TRACK) && (Ser_in != pred);
  assign Locked   = locked_q;

  nfsr_core u_core (
    .clk   (clk),
    .rst   (rst),
    .shift (shift_en),
    .din   (din),
    .q     (Par_out),
    .pred  (pred)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACQ;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ACQ: begin
        if (shift_en && (acq_cnt == 5'd23)) begin
          state_next = TRACK;
        end
      end
      TRACK: begin
        if (Mismatch && ((miss_cnt + 3'd1) == MISS_LIMIT)) begin
          state_next = ACQ;
        end
      end
      default: state_next = ACQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acq_cnt  <= '0;
      miss_cnt <= '0;
      Err_cnt  <= '0;
      locked_q <= 1'b0;
    end else begin
      locked_q <= (state_next == TRACK);
      if (shift_en) begin
        if (state == ACQ) begin
          acq_cnt  <= (acq_cnt == 5'd23) ? 5'd0 : acq_cnt + 5'd1;
          miss_cnt <= '0;
        end else if (Mismatch) begin
          miss_cnt <= (state_next == ACQ) ? 3'd0 : miss_cnt + 3'd1;
          acq_cnt  <= '0;
          if (Err_cnt != 8'hFF) begin
            Err_cnt <= Err_cnt + 8'd1;
          end
        end else begin
          miss_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_nfsr_rx_sync.sv
// Directed bench for nfsr_rx_sync: loopback from a behavioural transmitter plus a scoreboard model.
`timescale 1ns/1ps
module tb_nfsr_rx_sync;

  localparam int MISS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        shift_en;
  logic        ser_in;
  logic [23:0] par_out;
  logic        locked;
  logic        mismatch;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad   = 0;

  logic [23:0] m_r;
  logic        m_locked;
  int          m_acq;
  int          m_miss;
  int          m_err;

  logic [23:0] tx;
  logic [23:0] tx_hist[$];
  logic [23:0] cap;

  typedef struct packed {
    logic [23:0] par;
    logic        lck;
    logic [7:0]  err;
  } exp_t;
  exp_t sb[$];

  nfsr_rx_sync #(.MAX_MISS(MISS)) dut (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .Ser_in   (ser_in),
    .Par_out  (par_out),
    .Locked   (locked),
    .Mismatch (mismatch),
    .Err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic tfb(input logic [23:0] s);
    return s[23] ^ s[22] ^ s[21] ^ s[16] ^ (s[12] & s[7]) ^ (s[3] & s[1]);
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    e = sb.pop_front();
    cmp("par_out", 32'(par_out), 32'(e.par));
    cmp("locked", 32'(locked), 32'(e.lck));
    cmp("err_cnt", 32'(err_cnt), 32'(e.err));
  endtask

  task automatic applyStimulus(input logic r, input logic en, input logic b);
    logic p;
    logic exp_mm;
    exp_t e;
    @(negedge clk);
    rst = r;
    shift_en = en;
    ser_in = b;
    #1;
    p = tfb(m_r);
    exp_mm = !r && en && m_locked && (b != p);
    cmp("mismatch", 32'(mismatch), 32'(exp_mm));
    if (r) begin
      m_r = '0; m_locked = 1'b0; m_acq = 0; m_miss = 0; m_err = 0;
    end else if (en) begin
      if (!m_locked) begin
        m_r = {m_r[22:0], b};
        if (m_acq == 23) begin
          m_locked = 1'b1; m_acq = 0; m_miss = 0;
        end else begin
          m_acq++;
        end
      end else if (b == p) begin
        m_r = {m_r[22:0], b};
        m_miss = 0;
      end else begin
        m_r = {m_r[22:0], p};
        if (m_err < 255) m_err++;
        m_miss++;
        if (m_miss == MISS) begin
          m_locked = 1'b0; m_miss = 0; m_acq = 0;
        end
      end
    end
    e.par = m_r;
    e.lck = m_locked;
    e.err = 8'(m_err);
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic txBit(output logic b);
    b = tx[23];
    tx = {tx[22:0], tfb(tx)};
    tx_hist.push_back(tx);
  endtask

  task automatic sendGood();
    logic b;
    txBit(b);
    applyStimulus(1'b0, 1'b1, b);
  endtask

  task automatic sendFlip();
    logic b;
    txBit(b);
    applyStimulus(1'b0, 1'b1, ~b);
  endtask

  initial begin
    rst = 1'b1;
    shift_en = 1'b0;
    ser_in = 1'b0;
    m_r = '0; m_locked = 1'b0; m_acq = 0; m_miss = 0; m_err = 0;

    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    cmp("reset_par", 32'(par_out), 32'h0);
    cmp("reset_locked", 32'(locked), 32'h0);

    // Loopback acquisition from seed 24'h123456
    tx = 24'h123456;
    tx_hist.push_back(tx);
    repeat (23) sendGood();
    cmp("acq23_locked", 32'(locked), 32'h0);
    sendGood();
    cmp("lock_locked", 32'(locked), 32'h1);
    cmp("lock_par", 32'(par_out), 32'h123456);

    repeat (200) sendGood();
    cmp("track_delay", 32'(par_out), 32'(tx_hist[tx_hist.size()-25]));
    cmp("track_err", 32'(err_cnt), 32'h0);
    cmp("track_locked", 32'(locked), 32'h1);

    sendFlip();
    cmp("flip1_err", 32'(err_cnt), 32'h1);
    cmp("flip1_locked", 32'(locked), 32'h1);
    repeat (10) sendGood();
    cmp("flip1_after_err", 32'(err_cnt), 32'h1);

    // Three consecutive bad bits drop lock; re-acquisition needs 24 fresh bits
    repeat (2) sendFlip();
    cmp("flip2_locked", 32'(locked), 32'h1);
    sendFlip();
    cmp("drop_locked", 32'(locked), 32'h0);
    cmp("drop_err", 32'(err_cnt), 32'h4);
    repeat (23) sendGood();
    cmp("reacq23_locked", 32'(locked), 32'h0);
    sendGood();
    cmp("relock_locked", 32'(locked), 32'h1);
    cmp("relock_par", 32'(par_out), 32'(tx_hist[tx_hist.size()-25]));

    applyStimulus(1'b1, 1'b0, 1'b0);
    cap = tx;
    for (int i = 0; i < 48; i++) begin
      if (i % 2 == 1) sendGood();
      else applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end
    cmp("toggle_locked", 32'(locked), 32'h1);
    cmp("toggle_par", 32'(par_out), 32'(cap));

    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (10) sendGood();
    applyStimulus(1'b1, 1'b1, tx[23]);
    cmp("rst_acq_par", 32'(par_out), 32'h0);
    cmp("rst_acq_locked", 32'(locked), 32'h0);

    repeat (24) sendGood();
    repeat (2) sendFlip();
    cmp("pre_rst_err", 32'(err_cnt), 32'h2);
    applyStimulus(1'b1, 1'b1, 1'b1);
    cmp("rst_trk_err", 32'(err_cnt), 32'h0);
    cmp("rst_trk_locked", 32'(locked), 32'h0);
    cmp("rst_trk_par", 32'(par_out), 32'h0);

    // 300 mismatches while staying locked: two bad bits then one good bit
    repeat (24) sendGood();
    repeat (150) begin
      sendFlip();
      sendFlip();
      sendGood();
    end
    cmp("sat_err", 32'(err_cnt), 32'hFF);
    cmp("sat_locked", 32'(locked), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nfsr_rx_sync.md
NFSR_RX_SYNC -- requirements
Module: nfsr_rx_sync

Interface
REQ-001 The block SHALL have one parameter line: MAX_MISS, default 3, number of consecutive prediction mismatches in TRACK that drop lock (legal 1..7).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port shift_en, input, 1, qualifier: Ser_in is valid this cycle.
REQ-005 The block SHALL have port Ser_in, input, 1, received serial bit, MSB of the transmitter register first.
REQ-006 The block SHALL have port Par_out, output, 24, reconstructed NFSR state register R.
REQ-007 The block SHALL have port Locked, output, 1, high while in TRACK.
REQ-008 The block SHALL have port Mismatch, output, 1, one-cycle pulse on each mismatched bit in TRACK.
REQ-009 The block SHALL have port Err_cnt, output, 8, total mismatches since reset, saturating.

Function
REQ-010 Feedback function SHALL be fb(R) = R[23]^R[22]^R[21]^R[16]^(R[12]&R[7])^(R[3]&R[1]), identical to the transmitter nfsr (shift left, Ser_out = Q[23], Q <= {Q[22:0], fb}).
REQ-011 States SHALL be ACQ and TRACK; 5-bit acquire counter acq_cnt (0..24); 3-bit miss counter miss_cnt.
REQ-012 Cycles with shift_en=0 SHALL hold every register; Mismatch SHALL be 0.
REQ-013 ACQ, shift_en=1: R <= {R[22:0], Ser_in}, acq_cnt increments.
REQ-014 ACQ, shift_en=1 and acq_cnt==23: transition to TRACK, acq_cnt <= 0, miss_cnt <= 0; Locked high the following cycle, Par_out then equals the transmitter state captured at start of acquisition.
REQ-015 TRACK, shift_en=1: predicted bit p = fb(R); if Ser_in==p then R <= {R[22:0], Ser_in}, miss_cnt <= 0.
REQ-016 TRACK, shift_en=1, Ser_in!=p: Mismatch=1 same cycle (combinational from registered R and Ser_in), Err_cnt increments, miss_cnt increments, R <= {R[22:0], p} (flywheel on prediction).
REQ-017 When a mismatch makes miss_cnt reach MAX_MISS: transition to ACQ, acq_cnt <= 0, miss_cnt <= 0, R retained (overwritten by re-acquisition).
REQ-018 Err_cnt SHALL saturate at 255; further mismatches leave it at 255.
REQ-019 Locked SHALL be a registered decode of state (TRACK); no combinational path from Ser_in.
REQ-020 Latency: Par_out reflects a shifted bit one cycle after its shift_en cycle.

Reset
REQ-021 rst=1 SHALL force state ACQ, R=0, acq_cnt=0, miss_cnt=0, Err_cnt=0; outputs Par_out=0, Locked=0, Mismatch=0.
REQ-022 rst SHALL take priority over shift_en; reset mid-acquisition or mid-track discards all partial state.

Structure
REQ-023 Width 24, the tap function fb, and the state enum {ACQ, TRACK} SHALL live in a shared package nfsr_pkg used by both nfsr and nfsr_rx_sync.
REQ-024 The 24-bit register with fb SHALL be a sub-module nfsr_core (load-serial, shift, hold), instantiated once; control FSM stays in nfsr_rx_sync.

Verification
REQ-025 Loopback: nfsr seeded 24'h123456, Ser_out -> Ser_in, shift_en=1 for 24 cycles -> Locked=1 on cycle 25, Par_out=24'h123456.
REQ-026 Continued loopback 200 cycles -> Locked stays 1, Mismatch never 1, Err_cnt=0, Par_out tracks transmitter Par_out delayed by 24 shifts.
REQ-027 Single bit flip in TRACK (MAX_MISS=3) -> one Mismatch pulse, Err_cnt=1, Locked stays 1, next correct bits give no mismatch.
REQ-028 Three consecutive flipped bits -> Err_cnt=3, Locked=0 the cycle after the third, 24 further good bits -> Locked=1.
REQ-029 shift_en toggled 0/1 every cycle during acquisition -> lock after exactly 24 enabled bits (48 cycles), holds unchanged on disabled cycles.
REQ-030 rst asserted at acquisition bit 10, and again in TRACK with Err_cnt=2 -> all outputs 0 next cycle; 300 forced mismatches -> Err_cnt saturates at 255.
